cp0_exception_sequencer: RTL and testbench
==========================================

Name: cp0_exception_sequencer

Overview:
Pipeline-side controller that sequences exception entry and exception return around the coprocessor 0 block. It watches CP0's pendingexception/exccode and the ERET decode, waits for in-flight multi-cycle memory operations to drain, then drives the one-cycle activeexception/eret pulses into CP0. It also drives pipeline stall/flush and a PC redirect to the exception vector or to EPC. It sits between the CP0 block, the hazard unit and the PC-select mux.

Parameters:
EXC_VECTOR, 32'h80000180, general exception vector
INT_VECTOR, 32'h80000200, interrupt vector, used when exccode==0 and iv==1
DRAIN_MAX, 8, max cycles spent in DRAIN before forced entry (>=1)
CNT_W, 16, width of exception entry counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
pendingexception  input  1  from CP0; level, an exception/interrupt is requested
exccode  input  5  from CP0 exception unit; 0 = interrupt
iv  input  1  Cause.IV; selects INT_VECTOR for interrupts
mem_busy  input  1  multi-cycle load/store in flight; must not be flushed
eret_req  input  1  ERET decoded and valid in execute
epc  input  32  current EPC from CP0
activeexception  output  1  one-cycle pulse to CP0 (EPC/Status/Cause capture)
eret  output  1  one-cycle pulse to CP0 Status (restore)
stall  output  1  freeze fetch/decode
flush  output  1  kill IF/ID/EX contents
pc_redirect  output  1  one-cycle; PC <= pc_target
pc_target  output  32  redirect address
drain_timeout  output  1  sticky; forced entry occurred
exc_count  output  CNT_W  number of exception entries, wraps

Behaviour:
- Single clock, one domain. Reset is synchronous, active-high; all state updates on posedge clk.
- All control outputs are Moore, decoded from the registered state.
- Reset values: state IDLE; activeexception, eret, stall, flush, pc_redirect = 0; pc_target = 0; drain_timeout = 0; exc_count = 0; drain counter = 0.
- States: IDLE, DRAIN, ENTER, REDIRECT, ERET_RET, HOLD.
- IDLE, all outputs 0:
  - pendingexception=1: latch vec = (exccode==0 && iv) ? INT_VECTOR : EXC_VECTOR. Go to DRAIN if mem_busy, else ENTER.
  - else if eret_req=1: go to ERET_RET.
  - pendingexception has priority over eret_req when both are high in the same cycle.
- DRAIN: stall=1, drain counter increments.
  - pendingexception falls to 0 (interrupt withdrawn): return to IDLE, no entry, counter cleared.
  - else if mem_busy=0: go to ENTER.
  - else if counter==DRAIN_MAX-1: go to ENTER and set drain_timeout.
- ENTER: activeexception=1, stall=1, flush=1, exc_count+1 (wraps at 2^CNT_W). Go to REDIRECT.
- REDIRECT: pc_redirect=1, pc_target=vec, flush=1, stall=1. Go to HOLD.
- ERET_RET: eret=1, pc_redirect=1, pc_target=epc sampled this cycle, flush=1, stall=1. Go to HOLD.
- HOLD: all outputs 0; pendingexception and eret_req are ignored for one cycle (the pipeline is refilling). Go to IDLE.
- Latency: pendingexception sampled at edge N with mem_busy=0 gives activeexception in cycle N+1, pc_redirect in N+2, and IDLE in N+4. ERET gives eret and pc_redirect together in N+1.
- pc_target holds its last value when pc_redirect=0.
- drain_timeout clears only on reset.
- Reset asserted in any state returns to IDLE with reset values on the next edge; exc_count is cleared.

Decomposition:
- Package cp0_pkg: state enum, EXC_INT=5'd0, default vector constants.
- Shared with cp0_exception/cp0_cause for exccode encoding.
- No sub-module; the drain counter stays inline.

Test Plan:
- syscall exccode=8, mem_busy=0 at edge 10 -> activeexception=1 in cycle 11 only; pc_redirect=1, pc_target=32'h80000180 in cycle 12; exc_count=1.
- interrupt exccode=0, iv=1, mem_busy high for 3 cycles -> stall held 3 cycles in DRAIN, then ENTER; pc_target=32'h80000200.
- eret_req with epc=32'h00400020 -> eret=1 and pc_redirect=1 in the next cycle, pc_target=32'h00400020; activeexception stays 0.
- pendingexception and eret_req high together -> exception path taken; eret never pulses.
- mem_busy stuck at 1, DRAIN_MAX=8 -> ENTER 8 cycles after DRAIN entry, drain_timeout=1 and sticky. Separately: pendingexception dropped in DRAIN cycle 2 -> IDLE with no activeexception.
- reset asserted during ENTER -> next cycle all outputs 0, state IDLE, exc_count=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 encodings: exception-sequencer states, exccode values and default vectors.
package cp0_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ENTER,
        S_REDIRECT,
        S_ERET_RET,
        S_HOLD
    } seq_state_t;

    localparam logic [4:0]  EXC_INT        = 5'd0;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;
    localparam logic [31:0] DEF_INT_VECTOR = 32'h8000_0200;

endpackage

// File: rtl/cp0_exception_sequencer.sv
// Sequences exception entry / ERET around CP0: drains in-flight memory ops,
// pulses activeexception/eret, and drives stall, flush and the PC redirect.
module cp0_exception_sequencer
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR,
    parameter int          DRAIN_MAX  = 8,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pendingexception,
    input  logic [4:0]       exccode,
    input  logic             iv,
    input  logic             mem_busy,
    input  logic             eret_req,
    input  logic [31:0]      epc,
    output logic             activeexception,
    output logic             eret,
    output logic             stall,
    output logic             flush,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic             drain_timeout,
    output logic [CNT_W-1:0] exc_count
);

    localparam int          DCW        = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

    seq_state_t        r_state;
    logic [DCW-1:0]    r_drain_cnt;
    logic [31:0]       r_vec;
    logic [31:0]       r_pc_target;
    logic              r_act, r_eret, r_stall, r_flush, r_redir, r_timeout;
    logic [CNT_W-1:0]  r_exc_count;

    seq_state_t        w_nxt;
    logic              w_timeout_hit;

    always_comb begin
        w_nxt         = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pendingexception) w_nxt = mem_busy ? S_DRAIN : S_ENTER;
                else if (eret_req)    w_nxt = S_ERET_RET;
            end
            S_DRAIN: begin
                // A withdrawn interrupt abandons the entry entirely.
                if (!pendingexception)              w_nxt = S_IDLE;
                else if (!mem_busy)                 w_nxt = S_ENTER;
                else if (r_drain_cnt == DRAIN_LAST) begin
                    w_nxt         = S_ENTER;
                    w_timeout_hit = 1'b1;
                end
            end
            S_ENTER:    w_nxt = S_REDIRECT;
            S_REDIRECT: w_nxt = S_HOLD;
            S_ERET_RET: w_nxt = S_HOLD;
            S_HOLD:     w_nxt = S_IDLE;
            default:    w_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the state being entered, so they are a
    // pure function of the registered state during each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
            r_vec       <= '0;
            r_pc_target <= '0;
            r_act       <= 1'b0;
            r_eret      <= 1'b0;
            r_stall     <= 1'b0;
            r_flush     <= 1'b0;
            r_redir     <= 1'b0;
            r_timeout   <= 1'b0;
            r_exc_count <= '0;
        end else begin
            r_state <= w_nxt;
            r_act   <= (w_nxt == S_ENTER);
            r_eret  <= (w_nxt == S_ERET_RET);
            r_stall <= w_nxt inside {S_DRAIN, S_ENTER, S_REDIRECT, S_ERET_RET};
            r_flush <= w_nxt inside {S_ENTER, S_REDIRECT, S_ERET_RET};
            r_redir <= w_nxt inside {S_REDIRECT, S_ERET_RET};

            if (r_state == S_IDLE && pendingexception)
                r_vec <= (exccode == EXC_INT && iv) ? INT_VECTOR : EXC_VECTOR;

            if (w_nxt == S_REDIRECT)
                r_pc_target <= r_vec;
            else if (w_nxt == S_ERET_RET)
                r_pc_target <= epc;

            if (w_nxt == S_ENTER)
                r_exc_count <= r_exc_count + 1'b1;

            if (w_timeout_hit)
                r_timeout <= 1'b1;

            r_drain_cnt <= (r_state == S_DRAIN && w_nxt == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
        end
    end

    assign activeexception = r_act;
    assign eret            = r_eret;
    assign stall           = r_stall;
    assign flush           = r_flush;
    assign pc_redirect     = r_redir;
    assign pc_target       = r_pc_target;
    assign drain_timeout   = r_timeout;
    assign exc_count       = r_exc_count;

endmodule

// File: tb/tb_cp0_exception_sequencer.sv
// Directed bench: per-cycle vector table plus hand sequences for drain,
// withdrawal and reset-in-ENTER corner cases.
module tb_cp0_exception_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pendingexception;
    logic [4:0]  exccode;
    logic        iv;
    logic        mem_busy;
    logic        eret_req;
    logic [31:0] epc;
    logic        activeexception, eret, stall, flush, pc_redirect, drain_timeout;
    logic [31:0] pc_target;
    logic [15:0] exc_count;

    int n_chk  = 0;
    int n_fail = 0;

    cp0_exception_sequencer dut (
        .clk(clk), .reset(reset),
        .pendingexception(pendingexception), .exccode(exccode), .iv(iv),
        .mem_busy(mem_busy), .eret_req(eret_req), .epc(epc),
        .activeexception(activeexception), .eret(eret), .stall(stall),
        .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .drain_timeout(drain_timeout), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    // in  = {pend, iv, busy, eret_req}
    // out = {act, eret, stall, flush, redir, timeout}
    typedef struct {
        logic [3:0]  in;
        logic [4:0]  code;
        logic [31:0] epc;
        logic [5:0]  out;
        logic [31:0] tgt;
        logic [15:0] cnt;
    } vec_t;

    localparam logic [5:0] O_ZERO  = 6'b000000;
    localparam logic [5:0] O_DRAIN = 6'b001000;
    localparam logic [5:0] O_ENTER = 6'b101100;
    localparam logic [5:0] O_REDIR = 6'b001110;
    localparam logic [5:0] O_ERET  = 6'b011110;

    vec_t tv [23];

    function automatic vec_t mk(input logic [3:0] i, input logic [4:0] c, input logic [31:0] e,
                                input logic [5:0] o, input logic [31:0] t, input logic [15:0] n);
        vec_t v;
        v.in = i; v.code = c; v.epc = e; v.out = o; v.tgt = t; v.cnt = n;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] o, input logic [31:0] t,
                           input logic [15:0] n);
        chk({tag, ".activeexception"}, 32'(activeexception), 32'(o[5]));
        chk({tag, ".eret"},            32'(eret),            32'(o[4]));
        chk({tag, ".stall"},           32'(stall),           32'(o[3]));
        chk({tag, ".flush"},           32'(flush),           32'(o[2]));
        chk({tag, ".pc_redirect"},     32'(pc_redirect),     32'(o[1]));
        chk({tag, ".drain_timeout"},   32'(drain_timeout),   32'(o[0]));
        chk({tag, ".pc_target"},       pc_target,            t);
        chk({tag, ".exc_count"},       32'(exc_count),       32'(n));
    endtask

    task automatic drive(input logic [3:0] i, input logic [4:0] c, input logic [31:0] e);
        pendingexception = i[3];
        iv               = i[2];
        mem_busy         = i[1];
        eret_req         = i[0];
        exccode          = c;
        epc              = e;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = mk(4'b0000, 5'd0, 32'h0,         O_ZERO,  32'h0,         16'd0);
        tv[1]  = mk(4'b1000, 5'd8, 32'h0,         O_ENTER, 32'h0,         16'd1);
        tv[2]  = mk(4'b1000, 5'd8, 32'h0,         O_REDIR, 32'h8000_0180, 16'd1);
        tv[3]  = mk(4'b0000, 5'd0, 32'h0,         O_ZERO,  32'h8000_0180, 16'd1);
        tv[4]  = mk(4'b0000, 5'd0, 32'h0,         O_ZERO,  32'h8000_0180, 16'd1);
        tv[5]  = mk(4'b0001, 5'd0, 32'h0040_0020, O_ERET,  32'h0040_0020, 16'd1);
        tv[6]  = mk(4'b0000, 5'd0, 32'h0040_0020, O_ZERO,  32'h0040_0020, 16'd1);
        tv[7]  = mk(4'b0000, 5'd0, 32'h0040_0020, O_ZERO,  32'h0040_0020, 16'd1);
        tv[8]  = mk(4'b1001, 5'd8, 32'h0040_0020, O_ENTER, 32'h0040_0020, 16'd2);
        tv[9]  = mk(4'b1001, 5'd8, 32'h0040_0020, O_REDIR, 32'h8000_0180, 16'd2);
        tv[10] = mk(4'b1001, 5'd8, 32'h0040_0020, O_ZERO,  32'h8000_0180, 16'd2);
        tv[11] = mk(4'b0000, 5'd0, 32'h0,         O_ZERO,  32'h8000_0180, 16'd2);
        tv[12] = mk(4'b1110, 5'd0, 32'h0,         O_DRAIN, 32'h8000_0180, 16'd2);
        tv[13] = mk(4'b1110, 5'd0, 32'h0,         O_DRAIN, 32'h8000_0180, 16'd2);
        tv[14] = mk(4'b1110, 5'd0, 32'h0,         O_DRAIN, 32'h8000_0180, 16'd2);
        tv[15] = mk(4'b1100, 5'd0, 32'h0,         O_ENTER, 32'h8000_0180, 16'd3);
        tv[16] = mk(4'b0000, 5'd0, 32'h0,         O_REDIR, 32'h8000_0200, 16'd3);
        tv[17] = mk(4'b0000, 5'd0, 32'h0,         O_ZERO,  32'h8000_0200, 16'd3);
        tv[18] = mk(4'b0000, 5'd0, 32'h0,         O_ZERO,  32'h8000_0200, 16'd3);
        tv[19] = mk(4'b1000, 5'd0, 32'h0,         O_ENTER, 32'h8000_0200, 16'd4);
        tv[20] = mk(4'b0000, 5'd0, 32'h0,         O_REDIR, 32'h8000_0180, 16'd4);
        tv[21] = mk(4'b0000, 5'd0, 32'h0,         O_ZERO,  32'h8000_0180, 16'd4);
        tv[22] = mk(4'b0000, 5'd0, 32'h0,         O_ZERO,  32'h8000_0180, 16'd4);

        reset = 1'b1;
        drive(4'b0000, 5'd0, 32'h0);
        step();
        step();
        chk_out("reset", O_ZERO, 32'h0, 16'd0);
        reset = 1'b0;

        foreach (tv[i]) begin
            drive(tv[i].in, tv[i].code, tv[i].epc);
            step();
            chk_out($sformatf("vec%0d", i), tv[i].out, tv[i].tgt, tv[i].cnt);
        end

        // Interrupt withdrawn during the second DRAIN cycle.
        drive(4'b1010, 5'd8, 32'h0);
        step();
        chk_out("wd.drain1", O_DRAIN, 32'h8000_0180, 16'd4);
        step();
        chk_out("wd.drain2", O_DRAIN, 32'h8000_0180, 16'd4);
        drive(4'b0010, 5'd8, 32'h0);
        step();
        chk_out("wd.idle", O_ZERO, 32'h8000_0180, 16'd4);
        drive(4'b0000, 5'd0, 32'h0);
        step();
        chk_out("wd.idle2", O_ZERO, 32'h8000_0180, 16'd4);

        // mem_busy stuck: 8 DRAIN cycles, then forced entry.
        drive(4'b1010, 5'd8, 32'h0);
        step();
        chk_out("to.drain0", O_DRAIN, 32'h8000_0180, 16'd4);
        for (int k = 1; k < 8; k++) begin
            step();
            chk_out($sformatf("to.drain%0d", k), O_DRAIN, 32'h8000_0180, 16'd4);
        end
        step();
        chk_out("to.enter", 6'b101101, 32'h8000_0180, 16'd5);
        drive(4'b0000, 5'd0, 32'h0);
        step();
        chk_out("to.redir", 6'b001111, 32'h8000_0180, 16'd5);
        step();
        step();
        chk_out("to.sticky", 6'b000001, 32'h8000_0180, 16'd5);

        // Reset while in ENTER.
        drive(4'b1000, 5'd8, 32'h0);
        step();
        chk_out("rst.enter", 6'b101101, 32'h8000_0180, 16'd6);
        reset = 1'b1;
        step();
        chk_out("rst.cleared", O_ZERO, 32'h0, 16'd0);
        reset = 1'b0;
        drive(4'b0000, 5'd0, 32'h0);
        step();
        chk_out("rst.idle", O_ZERO, 32'h0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
